// File: rtl/step_accum_counter.sv
// Saturating/wrapping step accumulator built from a ripple of 2-bit digit adders.
// Emits carry and match pulses plus a sticky overflow level, and exposes its FSM state.
module step_accum_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       step,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic             match,
    output logic             ovf,
    output logic [1:0]       state
);
    // Handshake: a step is taken on a rising edge when in_valid=1, in_ready=1 and clr=0.
    // in_ready depends only on the registered state, never on in_valid.

    localparam int NDIG = WIDTH / 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_OVF  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             match_q, match_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum_lo;
    logic [NDIG:0]    dig_c;
    logic             accept;

    assign addend   = {{(WIDTH-2){1'b0}}, step};
    assign dig_c[0] = 1'b0;

    // LSB digit first; each digit's carry-out feeds the next digit.
    for (genvar i = 0; i < NDIG; i++) begin : g_digit
        assign {dig_c[i+1], sum_lo[2*i+1:2*i]} = {1'b0, count_q[2*i+1:2*i]}
                                                + {1'b0, addend[2*i+1:2*i]}
                                                + {2'b00, dig_c[i]};
    end

    assign in_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign accept   = in_valid && in_ready && !clr;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        carry_d = 1'b0;
        match_d = 1'b0;
        if (clr) begin
            state_d = ST_IDLE;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (accept) begin
            state_d = ST_RUN;
            count_d = sum_lo;
            if (dig_c[NDIG]) begin
                if (sat_mode) begin
                    count_d = '1;
                    ovf_d   = 1'b1;
                    state_d = ST_OVF;
                end else begin
                    carry_d = 1'b1;
                end
            end
            match_d = (count_d == target);
        end else if (state_q != ST_IDLE && state_q != ST_RUN && state_q != ST_OVF) begin
            // Unused encoding falls back to IDLE.
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            carry_q <= 1'b0;
            match_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            carry_q <= carry_d;
            match_q <= match_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign carry = carry_q;
    assign match = match_q;
    assign ovf   = ovf_q;
    assign state = state_q;

endmodule

// File: tb/tb_step_accum_counter.sv
// Bench for step_accum_counter: arithmetic reference model feeds an expected queue,
// a monitor compares every post-edge output snapshot against it.
module tb_step_accum_counter;
  localparam int WIDTH = 8;
  localparam int VW = WIDTH + 6;
  localparam int MAXV = (1 << WIDTH) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [1:0] step = 2'd0;
  logic sat_mode = 1'b0;
  logic [WIDTH-1:0] target = '0;
  logic [WIDTH-1:0] count;
  logic carry, match, ovf;
  logic [1:0] state;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int m_cnt = 0;
  int m_ovf = 0;
  int m_st = 0;   // 0 idle, 1 run, 2 ovf

  logic [VW-1:0] exp_q[$];

  step_accum_counter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .step(step), .sat_mode(sat_mode), .target(target), .count(count),
    .carry(carry), .match(match), .ovf(ovf), .state(state)
  );

  // clock/reset
  always #5 clk = ~clk;

  function automatic logic [VW-1:0] pack(input int cnt, input int cy, input int mt,
                                         input int ov, input int st);
    logic [31:0] c32;
    logic [31:0] s32;
    c32 = cnt;
    s32 = st;
    return {c32[WIDTH-1:0], cy != 0, mt != 0, ov != 0, s32[1:0], st != 2};
  endfunction

  function automatic logic [VW-1:0] dut_snap();
    return {count, carry, match, ovf, state, in_ready};
  endfunction

  function automatic void report(input string name, input logic [VW-1:0] got,
                                 input logic [VW-1:0] want);
    $display("FAIL %s: got count=%0d carry=%0b match=%0b ovf=%0b state=%0d ready=%0b, want count=%0d carry=%0b match=%0b ovf=%0b state=%0d ready=%0b",
             name, got[VW-1:6], got[5], got[4], got[3], got[2:1], got[0],
             want[VW-1:6], want[5], want[4], want[3], want[2:1], want[0]);
  endfunction

  // driver: apply one cycle of inputs at negedge, push the model's post-edge result
  task automatic drive(input int v, input int s, input int sm, input int tg, input int c);
    int sum;
    int cy;
    int mt;
    logic [31:0] s32;
    logic [31:0] t32;
    @(negedge clk);
    s32 = s;
    t32 = tg;
    in_valid = (v != 0);
    step = s32[1:0];
    sat_mode = (sm != 0);
    target = t32[WIDTH-1:0];
    clr = (c != 0);
    cy = 0;
    mt = 0;
    if (c != 0) begin
      m_cnt = 0; m_ovf = 0; m_st = 0;
    end else if (v != 0 && m_st != 2) begin
      sum = m_cnt + s;
      if (sum > MAXV && sm != 0) begin
        m_cnt = MAXV; m_ovf = 1; m_st = 2;
      end else begin
        if (sum > MAXV) cy = 1;
        m_cnt = sum % (MAXV + 1);
        m_st = 1;
      end
      mt = (m_cnt == (tg % (MAXV + 1))) ? 1 : 0;
    end
    exp_q.push_back(pack(m_cnt, cy, mt, m_ovf, m_st));
  endtask

  task automatic idle_cycle();
    drive(0, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, MAXV), 0);
  endtask

  // bring the model and DUT to a given count in wrap mode from a clear
  task automatic goto_count(input int val);
    drive(0, 0, 0, 0, 1);
    while (m_cnt < val) begin
      drive(1, (val - m_cnt > 3) ? 3 : val - m_cnt, 0, MAXV, 0);
    end
  endtask

  task automatic direct_check(input string name, input logic [VW-1:0] want);
    vectors++;
    if (dut_snap() !== want) begin
      miscompares++;
      report(name, dut_snap(), want);
    end
  endtask

  // scoreboard monitor
  initial begin
    logic [VW-1:0] want;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        vectors++;
        if (dut_snap() !== want) begin
          miscompares++;
          report("cycle", dut_snap(), want);
        end
      end
    end
  end

  initial begin
    int budget;
    #3;
    direct_check("reset_state", pack(0, 0, 0, 0, 0));
    #9 rst_n = 1'b1;

    // five step=3 accepts in wrap mode: 3,6,9,12,15
    for (int i = 0; i < 5; i++) drive(1, 3, 0, 0, 0);
    idle_cycle();

    // wrap overflow from 254
    goto_count(254);
    drive(1, 3, 0, 0, 0);
    idle_cycle();

    // saturate from 254, further valids ignored, then clear
    goto_count(254);
    drive(1, 3, 1, MAXV, 0);
    for (int i = 0; i < 3; i++) drive(1, $urandom_range(0, 3), 0, MAXV, 0);
    drive(1, 2, 0, 0, 1);
    idle_cycle();

    // match at 8, then again with step=0
    goto_count(6);
    drive(1, 2, 0, 8, 0);
    drive(1, 0, 0, 8, 0);
    idle_cycle();

    // clr beats a simultaneous step
    goto_count(10);
    drive(1, 2, 0, 0, 1);
    idle_cycle();

    // step=0 from IDLE goes to RUN
    drive(1, 0, 0, 0, 0);

    // asynchronous reset between edges with count=77
    goto_count(77);
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    direct_check("async_reset", pack(0, 0, 0, 0, 0));
    #1 rst_n = 1'b1;
    m_cnt = 0; m_ovf = 0; m_st = 0;
    drive(1, 1, 0, 0, 0);
    idle_cycle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int v, s, sm, tg, c;
      v = ($urandom_range(0, 3) != 0);
      s = $urandom_range(0, 3);
      sm = ($urandom_range(0, 15) == 0);
      c = ($urandom_range(0, 63) == 0);
      tg = ($urandom_range(0, 1) != 0) ? (m_cnt + s) % (MAXV + 1) : $urandom_range(0, MAXV);
      drive(v, s, sm, tg, c);
    end
    drive(0, 0, 0, 0, 0);

    budget = 0;
    while (exp_q.size() > 0 && budget < 100) begin
      @(posedge clk);
      budget++;
    end
    #5;
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
